// File: rtl/pixel_spike_encoder.sv
// Rate-codes one frame of pixel intensities into NUM_STEPS spike vectors. Each spike
// is an LFSR threshold compare, and each timestep lasts PULSE_PERIOD clocks and ends with an integrate pulse.
module pixel_spike_encoder #(
  parameter int          N_PIXELS     = 5,
  parameter int          PIX_W        = 8,
  parameter int          NUM_STEPS    = 16,
  parameter int          PULSE_PERIOD = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  localparam int         STEP_W       = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1,
  localparam int         PH_W         = $clog2(PULSE_PERIOD)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_PIXELS*PIX_W-1:0] pixels_in,
  input  logic                      start,
  input  logic                      stop,
  output logic                      start_ready,
  output logic [N_PIXELS-1:0]       L_1_pexel,
  output logic                      pulse,
  output logic                      busy,
  output logic                      done,
  output logic [STEP_W-1:0]         step_idx,
  output logic [1:0]                fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                      state;
  logic [15:0]                 lfsr;
  logic [15:0]                 lfsr_next;
  logic [PH_W-1:0]             phase;
  logic [N_PIXELS*PIX_W-1:0]   pix_q;
  logic [N_PIXELS-1:0]         spikes;

  // Lane i compares against the low LFSR byte rotated left by (i mod 8), so lanes decorrelate.
  function automatic logic [N_PIXELS-1:0] enc(input logic [N_PIXELS*PIX_W-1:0] pix,
                                              input logic [15:0] l);
    logic [15:0]      dbl;
    logic [PIX_W-1:0] rnd;
    logic [PIX_W-1:0] p;
    enc = '0;
    for (int i = 0; i < N_PIXELS; i++) begin
      dbl    = {l[7:0], l[7:0]} << (i % 8);
      rnd    = PIX_W'(dbl[15:8]);
      p      = pix[PIX_W*i +: PIX_W];
      enc[i] = (p == {PIX_W{1'b1}}) || (p > rnd);
    end
  endfunction

  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // Handshake: start is accepted on a clock edge where start_ready=1. While busy=1, stop
  // aborts the frame at the next edge and takes priority over the step advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      lfsr     <= LFSR_SEED;
      phase    <= '0;
      step_idx <= '0;
      pix_q    <= '0;
      spikes   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pix_q    <= pixels_in;
            lfsr     <= LFSR_SEED;
            phase    <= '0;
            step_idx <= '0;
            spikes   <= enc(pixels_in, LFSR_SEED);
            state    <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state    <= IDLE;
            phase    <= '0;
            step_idx <= '0;
            spikes   <= '0;
          end else if (phase == PH_W'(PULSE_PERIOD - 1)) begin
            phase <= '0;
            if (step_idx < STEP_W'(NUM_STEPS - 1)) begin
              step_idx <= step_idx + 1'b1;
              lfsr     <= lfsr_next;
              spikes   <= enc(pix_q, lfsr_next);
            end else begin
              state  <= DONE;
              spikes <= '0;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          step_idx <= '0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // All outputs are registers or decodes of registers only.
  assign L_1_pexel   = spikes;
  assign pulse       = (state == RUN) && (phase == PH_W'(PULSE_PERIOD - 1));
  assign busy        = (state == RUN);
  assign done        = (state == DONE);
  assign start_ready = (state == IDLE);
  assign fsm_state   = state;

endmodule

// File: tb/tb_pixel_spike_encoder.sv
// Bench for pixel_spike_encoder. Expected spike traces come from a frame-level model
// of the threshold rule and the LFSR recurrence.
module tb_pixel_spike_encoder;

  localparam int N = 5;
  localparam int STEPS = 16;
  localparam int PP = 4;
  localparam int SEED = 16'hACE1;

  logic         clk = 1'b0;
  logic         reset;
  logic [N*8-1:0] pixels_in;
  logic         start;
  logic         stop;
  logic         start_ready;
  logic [N-1:0] L_1_pexel;
  logic         pulse;
  logic         busy;
  logic         done;
  logic [3:0]   step_idx;
  logic [1:0]   fsm_state;

  int checks = 0;
  int failures = 0;
  logic [N-1:0] exp_q[$];
  int lane_cnt[N];
  int ref_cnt[N];

  pixel_spike_encoder dut (
    .clk(clk), .reset(reset), .pixels_in(pixels_in), .start(start), .stop(stop),
    .start_ready(start_ready), .L_1_pexel(L_1_pexel), .pulse(pulse), .busy(busy),
    .done(done), .step_idx(step_idx), .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Spike rule: pixel value beats a per-lane rotated byte of the LFSR, saturated pixels always fire.
  function automatic logic [N-1:0] model_spikes(input logic [N*8-1:0] pix, input int l);
    logic [N-1:0] v;
    int p, r0, s, rnd;
    v = '0;
    for (int i = 0; i < N; i++) begin
      p   = int'((pix >> (8 * i)) & 40'hFF);
      r0  = l & 255;
      s   = i % 8;
      rnd = ((r0 << s) | (r0 >> (8 - s))) & 255;
      v[i] = (p == 255) || (p > rnd);
    end
    return v;
  endfunction

  function automatic void build_expected(input logic [N*8-1:0] pix);
    int l, fb;
    exp_q.delete();
    l = SEED;
    for (int t = 0; t < STEPS; t++) begin
      exp_q.push_back(model_spikes(pix, l));
      fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
      l  = ((l << 1) | fb) & 16'hFFFF;
    end
  endfunction

  function automatic logic [N*8-1:0] rand_pix();
    return {$urandom, $urandom};
  endfunction

  // Starts a frame and checks every clock through the return to IDLE.
  task automatic run_frame(input string name, input logic [N*8-1:0] pix, input bit jitter);
    logic [N+8:0] obs, exp;
    int pulses, dones, step;
    build_expected(pix);
    for (int i = 0; i < N; i++) lane_cnt[i] = 0;
    pulses = 0;
    dones = 0;
    pixels_in = pix;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= STEPS * PP + 2; c++) begin
      if (c > 1) tick();
      if (c <= STEPS * PP) begin
        step = (c - 1) / PP;
        exp = {exp_q[step], ((c - 1) % PP) == PP - 1, 1'b0, 1'b1, 1'b0, 4'(step)};
      end else if (c == STEPS * PP + 1) begin
        exp = {{N{1'b0}}, 1'b0, 1'b1, 1'b0, 1'b0, 4'(STEPS - 1)};
      end else begin
        exp = {{N{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};
      end
      obs = {L_1_pexel, pulse, done, busy, start_ready, step_idx};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL %s clk%0d {spk,pulse,done,busy,rdy,step}: got %b want %b", name, c, obs, exp);
      end
      if (pulse === 1'b1) begin
        pulses++;
        for (int i = 0; i < N; i++) lane_cnt[i] += int'(L_1_pexel[i]);
      end
      if (done === 1'b1) dones++;
      if (jitter) pixels_in = rand_pix();
    end
    checks++;
    if (pulses !== STEPS) begin
      failures++;
      $display("FAIL %s pulse_count: got %0d want %0d", name, pulses, STEPS);
    end
    checks++;
    if (dones !== 1) begin
      failures++;
      $display("FAIL %s done_count: got %0d want 1", name, dones);
    end
  endtask

  task automatic test_reset();
    logic [N*8-1:0] pix;
    reset = 1'b0; start = 1'b0; stop = 1'b0; pixels_in = '0;
    #12;
    checks++;
    if ({L_1_pexel, pulse, done, busy, start_ready, step_idx} !== {{N{1'b0}}, 4'b0001, 4'd0}) begin
      failures++;
      $display("FAIL reset_state: got %b", {L_1_pexel, pulse, done, busy, start_ready, step_idx});
    end
    @(negedge clk) reset = 1'b1;
    pix = rand_pix();
    pixels_in = pix;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    checks++;
    if (step_idx !== 4'd5 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_midframe_pre: step %0d busy %b want 5 1", step_idx, busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({L_1_pexel, pulse, done, busy, start_ready, step_idx} !== {{N{1'b0}}, 4'b0001, 4'd0}) begin
      failures++;
      $display("FAIL reset_midframe: got %b", {L_1_pexel, pulse, done, busy, start_ready, step_idx});
    end
    @(negedge clk) reset = 1'b1;
    run_frame("reset_restart", pix, 1'b0);
  endtask

  task automatic test_all_zero();
    run_frame("all_zero", '0, 1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (lane_cnt[i] !== 0) begin
        failures++;
        $display("FAIL all_zero lane%0d count: got %0d want 0", i, lane_cnt[i]);
      end
    end
  endtask

  task automatic test_all_full();
    run_frame("all_full", {N{8'hFF}}, 1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (lane_cnt[i] !== STEPS) begin
        failures++;
        $display("FAIL all_full lane%0d count: got %0d want %0d", i, lane_cnt[i], STEPS);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N*8-1:0] pix;
    int model_cnt;
    pix = {8'd255, 8'd192, 8'd128, 8'd64, 8'd0};
    run_frame("b2b_frame1", pix, 1'b0);
    for (int i = 0; i < N; i++) ref_cnt[i] = lane_cnt[i];
    for (int i = 0; i < N; i++) begin
      model_cnt = 0;
      foreach (exp_q[t]) model_cnt += int'(exp_q[t][i]);
      checks++;
      if (ref_cnt[i] !== model_cnt) begin
        failures++;
        $display("FAIL b2b lane%0d model count: got %0d want %0d", i, ref_cnt[i], model_cnt);
      end
    end
    run_frame("b2b_frame2", pix, 1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (lane_cnt[i] !== ref_cnt[i]) begin
        failures++;
        $display("FAIL b2b lane%0d repeat: got %0d want %0d", i, lane_cnt[i], ref_cnt[i]);
      end
    end
    checks++;
    if (ref_cnt[0] !== 0 || ref_cnt[4] !== STEPS) begin
      failures++;
      $display("FAIL b2b extremes: lane0 %0d lane4 %0d want 0 %0d", ref_cnt[0], ref_cnt[4], STEPS);
    end
  endtask

  task automatic test_stop();
    int pulses, dones;
    pulses = 0;
    pixels_in = rand_pix();
    start = 1'b1;
    tick();
    for (int c = 1; c < 3 * PP + PP; c++) begin
      if (c > 1) tick();
      checks++;
      if (step_idx !== 4'((c - 1) / PP) || busy !== 1'b1) begin
        failures++;
        $display("FAIL stop start_held clk%0d: step %0d busy %b want %0d 1", c, step_idx, busy, (c - 1) / PP);
      end
      if (pulse === 1'b1) pulses++;
    end
    tick();
    checks++;
    if (pulse !== 1'b1 || step_idx !== 4'd3) begin
      failures++;
      $display("FAIL stop pre_pulse: pulse %b step %0d want 1 3", pulse, step_idx);
    end
    start = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if ({L_1_pexel, pulse, done, busy, start_ready, step_idx} !== {{N{1'b0}}, 4'b0001, 4'd0}) begin
      failures++;
      $display("FAIL stop_abort: got %b", {L_1_pexel, pulse, done, busy, start_ready, step_idx});
    end
    checks++;
    if (pulses !== 3) begin
      failures++;
      $display("FAIL stop pulses_before: got %0d want 3", pulses);
    end
    dones = 0;
    repeat (10) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      failures++;
      $display("FAIL stop no_done: got %0d active clocks want 0", dones);
    end
    start = 1'b1;
    stop = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    checks++;
    if (busy !== 1'b1 || step_idx !== 4'd0) begin
      failures++;
      $display("FAIL start_stop_idle: busy %b step %0d want 1 0", busy, step_idx);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_second_abort: rdy %b busy %b want 1 0", start_ready, busy);
    end
  endtask

  task automatic test_pixel_jitter();
    run_frame("pixel_jitter", {8'd255, 8'd192, 8'd128, 8'd64, 8'd0}, 1'b1);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (lane_cnt[i] !== ref_cnt[i]) begin
        failures++;
        $display("FAIL pixel_jitter lane%0d: got %0d want %0d", i, lane_cnt[i], ref_cnt[i]);
      end
    end
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 4; k++) run_frame("random", rand_pix(), 1'b0);
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_all_full();
    test_back_to_back();
    test_stop();
    test_pixel_jitter();
    test_random_frames();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
